seq_restoring_divider: RTL and testbench

//  Iterative radix-2 restoring divider: the inverse of the Wallace/Dadda multipliers.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 22 ++
 rtl/seq_restoring_divider.sv | 100 ++++++++++
 tb/tb_seq_restoring_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W       = 8;
    localparam int DIV_LATENCY = 2*DIV_W + 1;

    function automatic int div_cnt_width(input int w);
        return $clog2(2*w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring stage: shift in a dividend bit, subtract the divisor if it fits.
// Zero latency; no flow control.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   pr_in,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    always_comb begin
        shifted = {pr_in[W-1:0], dvd_bit};
        // A set top bit means the shifted value has outgrown W+1 bits, so the divisor surely fits.
        q_bit   = pr_in[W] | (shifted >= {1'b0, divisor});
        pr_out  = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// done arrives 2W+1 cycles after an accepted start; start is ignored while busy.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int            CW   = div_cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(2*W - 1);

    div_state_t     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   dvsr;
    logic [W-1:0]   dvd_lo;
    logic [2*W-1:0] q_sr;
    logic [W:0]     pr;
    logic [W:0]     pr_nxt;
    logic           q_bit;
    logic           dbz;
    logic           accept;
    logic           last_step;

    div_step #(.W(W)) u_step (
        .pr_in   (pr),
        .dvd_bit (q_sr[2*W-1]),
        .divisor (dvsr),
        .pr_out  (pr_nxt),
        .q_bit   (q_bit)
    );

    assign ready     = (state == IDLE) || (state == DONE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = start & ready;
    assign last_step = busy && (cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dvsr        <= '0;
            dvd_lo      <= '0;
            q_sr        <= '0;
            pr          <= '0;
            dbz         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            dvsr        <= divisor;
            dvd_lo      <= dividend[W-1:0];
            q_sr        <= dividend;
            pr          <= '0;
            dbz         <= (divisor == '0);
            div_by_zero <= 1'b0;
        end else if (busy) begin
            cnt  <= cnt + CW'(1);
            pr   <= pr_nxt;
            q_sr <= {q_sr[2*W-2:0], q_bit};
            // Results are published only once, so the previous answer stays visible during RUN.
            if (last_step) begin
                quotient    <= dbz ? '1 : {q_sr[2*W-2:0], q_bit};
                remainder   <= dbz ? dvd_lo : pr_nxt[W-1:0];
                div_by_zero <= dbz;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider with a queue scoreboard of expected results.
module tb_seq_restoring_divider;
    import div_pkg::*;

    localparam int W = DIV_W;

    typedef struct packed {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        e.dbz    = (dvs == '0);
        if (e.dbz) begin
            e.q = '1;
            e.r = dvd[W-1:0];
        end else begin
            e.q = dvd / dvs;
            e.r = W'(dvd % dvs);
        end
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Called right after issue(): lat counts the cycle that began at the start edge as 1.
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_q"},   quotient,    e.q);
            chk({tag, "_r"},   remainder,   e.r);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    initial begin
        int lat;
        int dones;
        int pa;
        int pb;
        bit first;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        chk("rst_q",     quotient,    0);
        chk("rst_r",     remainder,   0);
        chk("rst_dbz",   div_by_zero, 0);
        chk("rst_done",  done,        0);
        chk("rst_busy",  busy,        0);
        chk("rst_ready", ready,       1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // T1
        issue(16'd100, 8'd7);
        chk("T1_busy",  busy,  1);
        chk("T1_ready", ready, 0);
        wait_done("T1", lat);
        chk("T1_lat", lat, DIV_LATENCY);
        check_result("T1");
        tick();
        chk("T1_pulse", done,  0);
        chk("T1_idle",  ready, 1);

        // T2
        issue(16'd65025, 8'd255);
        wait_done("T2a", lat);
        check_result("T2a");
        issue(16'd65535, 8'd1);
        wait_done("T2b", lat);
        chk("T2b_lat", lat, DIV_LATENCY);
        check_result("T2b");
        tick();

        // T3
        issue(16'd1234, 8'd0);
        wait_done("T3", lat);
        chk("T3_lat", lat, DIV_LATENCY);
        check_result("T3");
        tick();

        // T4
        issue(16'd50, 8'd3);
        chk("T4_dbz_clr", div_by_zero, 0);
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    chk("T4_lat", c, DIV_LATENCY);
                    check_result("T4");
                end
            end
            if (c == 5) chk("T4_hold_q", quotient, 16'hFFFF);
            if (c == 3 || c == 9) begin
                start    = 1'b1;
                dividend = 16'd999;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("T4_dones", dones, 1);

        // T5
        issue(16'd200, 8'd3);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("T5_q",     quotient,    0);
        chk("T5_r",     remainder,   0);
        chk("T5_dbz",   div_by_zero, 0);
        chk("T5_done",  done,        0);
        chk("T5_busy",  busy,        0);
        chk("T5_ready", ready,       1);
        sb.delete();
        tick();
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("T5_no_done", dones, 0);
        issue(16'd9, 8'd4);
        wait_done("T5b", lat);
        check_result("T5b");

        // T6: back-to-back sweep, each start issued on the previous done cycle
        first = 1'b1;
        pa = 0;
        pb = 0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 64; b++) begin
                if (!first) begin
                    wait_done($sformatf("T6 a=%0d b=%0d", pa, pb), lat);
                    chk($sformatf("T6 a=%0d b=%0d lat", pa, pb), lat, DIV_LATENCY);
                    check_result($sformatf("T6 a=%0d b=%0d", pa, pb));
                end
                issue(16'(a*b), 8'(b));
                first = 1'b0;
                pa = a;
                pb = b;
            end
        end
        wait_done($sformatf("T6 a=%0d b=%0d", pa, pb), lat);
        check_result($sformatf("T6 a=%0d b=%0d", pa, pb));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
